// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the PC fetch unit: FSM state encoding and the
// default values of the top-level parameters.
package fetch_pkg;

    typedef enum logic [1:0] {
        StBoot   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } fetch_state_e;

    localparam int unsigned XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEFAULT      = 4;
    localparam int unsigned QDEPTH_DEFAULT       = 2;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue
// Small circular FIFO holding {pc, instr} entries between the instruction
// memory response and the consumer.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push, i_wdata write an entry (accepted when not full, or full with pop)
//   i_pop           remove the head entry (ignored when empty)
//   i_flush         drop every entry; wins over push and pop
//   o_rdata         head entry
//   o_full, o_empty occupancy flags
//   o_count         number of stored entries
module fetch_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rptr];

    assign w_do_pop  = i_pop && !o_empty;
    // A full queue can still take a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Sequential instruction fetcher: issues one-cycle-latency instruction memory
// requests, queues the returned {pc, instr} pairs and presents them through a
// valid/ready interface. Supports redirect (flush + new pc) and halt.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   o_imem_req, o_imem_addr        fetch request and its address (= pc)
//   i_imem_rdata                   instruction, one cycle after the request
//   i_redirect_valid, i_redirect_pc redirect strobe and target
//   i_halt                         stop issuing new fetches
//   o_out_valid, i_out_ready       output handshake
//   o_out_pc, o_out_instr          presented entry (zero when queue empty)
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter int unsigned      PC_STEP      = PC_STEP_DEFAULT,
    parameter int unsigned      QDEPTH       = QDEPTH_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [XLEN-1:0] i_imem_rdata,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_halt,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_out_pc,
    output logic [XLEN-1:0] o_out_instr
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_inflight;
    logic [XLEN-1:0] r_inflight_pc;

    logic [2*XLEN-1:0] w_q_rdata;
    logic              w_q_full;
    logic              w_q_empty;
    logic [CW-1:0]     w_q_count;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [CW:0]       w_used;

    assign o_out_valid = (r_state != StBoot) && !w_q_empty;
    assign w_pop       = o_out_valid && i_out_ready;

    // Slots committed after this cycle's accepted pop; crediting the pop keeps
    // a steady one-entry-per-cycle stream with a two-entry queue.
    assign w_used = {1'b0, w_q_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);

    // Decoded combinationally so halt and redirect block a request the same cycle.
    assign w_issue = (r_state == StRun) && !i_halt && !i_redirect_valid
                     && (w_used < (CW+1)'(QDEPTH));

    // The credit check keeps the queue from overflowing; the full term only
    // guards against losing the response if that ever changes.
    assign w_push = r_inflight && !i_redirect_valid && (!w_q_full || w_pop);

    assign o_imem_req  = w_issue;
    assign o_imem_addr = r_pc;
    assign o_out_pc    = w_q_empty ? '0 : w_q_rdata[2*XLEN-1:XLEN];
    assign o_out_instr = w_q_empty ? '0 : w_q_rdata[XLEN-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StBoot;
            r_pc          <= RESET_VECTOR;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            unique case (r_state)
                StBoot:   r_state <= StRun;
                StRun:    if (i_halt)  r_state <= StHalted;
                StHalted: if (!i_halt) r_state <= StRun;
                default:  r_state <= StBoot;
            endcase

            // Redirect drops whatever response is due next cycle.
            if (i_redirect_valid) begin
                r_pc       <= i_redirect_pc;
                r_inflight <= 1'b0;
            end else if (w_issue) begin
                r_pc          <= r_pc + XLEN'(PC_STEP);
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_pc;
            end else begin
                r_inflight <= 1'b0;
            end
        end
    end

    fetch_queue #(
        .WIDTH (2 * XLEN),
        .DEPTH (QDEPTH)
    ) u_queue (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_redirect_valid),
        .i_wdata ({r_inflight_pc, i_imem_rdata}),
        .o_rdata (w_q_rdata),
        .o_full  (w_q_full),
        .o_empty (w_q_empty),
        .o_count (w_q_count)
    );

endmodule
